// File: rtl/cmip_1r1w_mem_rd_ctrl.sv
// cmip_1r1w_mem_rd_ctrl
// Read-side client of a 1R1W block memory with fixed read latency. A command
// (start address, length) is turned into one read per cycle, wrapping at DPTH.
// Returned words are realigned through a credit-protected first-word-fall-through
// buffer and delivered as a valid/ready stream with a last flag.
// Optional statistics counters (stall cycles, words delivered) are built when
// the macro CMIP_MEM_RD_STAT_EN is defined.
//
// state | meaning
// IDLE  | ready for a command; len==0 commands complete here with a done pulse
// RUN   | issuing reads while words remain and credit is available
// DRAIN | all reads issued; waiting for the last-tagged word to handshake
module cmip_1r1w_mem_rd_ctrl #(
   parameter int DPTH         = 16384,
   parameter int DATA_WDTH    = 2048,
   parameter int ADDR_WDTH    = $clog2(DPTH),
   parameter int READ_LATENCY = 4,
   parameter int LEN_WDTH     = 16,
   parameter int BUF_DPTH     = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_clr,
   input  logic                 i_cmd_vld,
   output logic                 o_cmd_rdy,
   input  logic [ADDR_WDTH-1:0] i_cmd_addr,
   input  logic [LEN_WDTH-1:0]  i_cmd_len,
   output logic                 o_mem_rd,
   output logic [ADDR_WDTH-1:0] o_mem_raddr,
   input  logic [DATA_WDTH-1:0] i_mem_rdata,
   output logic                 o_dout_vld,
   input  logic                 i_dout_rdy,
   output logic [DATA_WDTH-1:0] o_dout,
   output logic                 o_dout_last,
   output logic                 o_busy,
`ifdef CMIP_MEM_RD_STAT_EN
   output logic [31:0]          o_stall_cnt,
   output logic [31:0]          o_word_cnt,
`endif
   output logic                 o_done
);

   localparam int BPTR_W = (BUF_DPTH > 1) ? $clog2(BUF_DPTH) : 1;
   localparam int BCNT_W = $clog2(BUF_DPTH + 1);
   localparam int CRD_W  = $clog2(BUF_DPTH + READ_LATENCY + 2) + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WDTH-1:0]  addr_q, addr_d;
   logic [LEN_WDTH-1:0]   rem_q, rem_d;
   logic                  rd_q, rd_d;
   logic                  rd_last_q, rd_last_d;
   logic [ADDR_WDTH-1:0]  raddr_q, raddr_d;
   logic                  done_q, done_d;
   logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
   logic [READ_LATENCY-1:0] pipe_last_q, pipe_last_d;

   logic [DATA_WDTH-1:0]  buf_data_q [BUF_DPTH];
   logic [BUF_DPTH-1:0]   buf_last_q;
   logic [BPTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [BCNT_W-1:0]     buf_cnt_q;

   logic [CRD_W-1:0]      inflight;
   logic                  push, pop, head_last, can_issue;

   assign push        = pipe_vld_q[READ_LATENCY-1];
   assign o_dout_vld  = (buf_cnt_q != '0);
   assign pop         = o_dout_vld & i_dout_rdy;
   assign head_last   = buf_last_q[rd_ptr_q];
   assign o_dout      = buf_data_q[rd_ptr_q];
   assign o_dout_last = o_dout_vld & head_last;
   assign o_cmd_rdy   = (state_q == IDLE);
   assign o_busy      = (state_q != IDLE);
   assign o_mem_rd    = rd_q;
   assign o_mem_raddr = raddr_q;
   assign o_done      = done_q;

   // Outstanding reads: the registered read strobe plus every valid pipe slot.
   always_comb begin
      inflight = CRD_W'(rd_q);
      for (int k = 0; k < READ_LATENCY; k++) begin
         inflight = inflight + CRD_W'(pipe_vld_q[k]);
      end
   end

   // A pop this cycle earns no credit, which keeps the buffer from overflowing.
   assign can_issue = (rem_q != '0) &&
                      ((inflight + CRD_W'(buf_cnt_q)) < CRD_W'(BUF_DPTH));

   // Next state, read issue and address/length bookkeeping; i_clr overrides all.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      rd_d      = 1'b0;
      rd_last_d = 1'b0;
      raddr_d   = raddr_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_cmd_vld) begin
               if (i_cmd_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  addr_d  = i_cmd_addr;
                  rem_d   = i_cmd_len;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (can_issue) begin
               rd_d    = 1'b1;
               raddr_d = addr_q;
               addr_d  = (addr_q == ADDR_WDTH'(DPTH - 1)) ? '0 : addr_q + ADDR_WDTH'(1);
               rem_d   = rem_q - LEN_WDTH'(1);
               if (rem_q == LEN_WDTH'(1)) begin
                  rd_last_d = 1'b1;
                  state_d   = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop && head_last && (inflight == '0)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (i_clr) begin
         state_d   = IDLE;
         rem_d     = '0;
         rd_d      = 1'b0;
         rd_last_d = 1'b0;
         done_d    = 1'b0;
      end
   end

   // Latency pipe: slot 0 takes the registered read, the last slot pushes the buffer.
   always_comb begin
      pipe_vld_d     = '0;
      pipe_last_d    = '0;
      pipe_vld_d[0]  = rd_q;
      pipe_last_d[0] = rd_last_q;
      for (int k = 1; k < READ_LATENCY; k++) begin
         pipe_vld_d[k]  = pipe_vld_q[k-1];
         pipe_last_d[k] = pipe_last_q[k-1];
      end
      if (i_clr) begin
         pipe_vld_d = '0;
      end
   end

   // Control registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         rd_q        <= 1'b0;
         rd_last_q   <= 1'b0;
         raddr_q     <= '0;
         done_q      <= 1'b0;
         pipe_vld_q  <= '0;
         pipe_last_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         rd_q        <= rd_d;
         rd_last_q   <= rd_last_d;
         raddr_q     <= raddr_d;
         done_q      <= done_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_last_q <= pipe_last_d;
      end
   end

   // Return buffer: circular with explicit pointer wrap so depth need not be 2^n.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         buf_cnt_q  <= '0;
         buf_last_q <= '0;
         for (int k = 0; k < BUF_DPTH; k++) begin
            buf_data_q[k] <= '0;
         end
      end else if (i_clr) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         buf_cnt_q <= '0;
      end else begin
         if (push) begin
            buf_data_q[wr_ptr_q] <= i_mem_rdata;
            buf_last_q[wr_ptr_q] <= pipe_last_q[READ_LATENCY-1];
            wr_ptr_q <= (wr_ptr_q == BPTR_W'(BUF_DPTH - 1)) ? '0 : wr_ptr_q + BPTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == BPTR_W'(BUF_DPTH - 1)) ? '0 : rd_ptr_q + BPTR_W'(1);
         end
         if (push && !pop) begin
            buf_cnt_q <= buf_cnt_q + BCNT_W'(1);
         end else if (pop && !push) begin
            buf_cnt_q <= buf_cnt_q - BCNT_W'(1);
         end
      end
   end

`ifdef CMIP_MEM_RD_STAT_EN
   logic [31:0] stall_q, word_q;

   // Saturating stall-cycle and delivered-word counters, kept across commands.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stall_q <= '0;
         word_q  <= '0;
      end else if (i_clr) begin
         stall_q <= '0;
         word_q  <= '0;
      end else begin
         if (o_dout_vld && !i_dout_rdy && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
         end
         if (pop && (word_q != '1)) begin
            word_q <= word_q + 32'd1;
         end
      end
   end

   assign o_stall_cnt = stall_q;
   assign o_word_cnt  = word_q;
`endif

endmodule
